// File: rtl/dataload_ctrl.sv
// Loads a row-major element stream into BAND_WIDTH buffer banks, then hands off to the weight/setup side.
// Buffer writes trail the stream handshake by one cycle; s_ready_o is high only while loading.
module dataload_ctrl #(
    parameter int SRAM_DEPTH = 1024,
    parameter int BAND_WIDTH = 25,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  cfg_start_i,
    input  logic [10:0]                                           cfg_burst_size_i,
    input  logic                                                  s_valid_i,
    input  logic [DATA_WIDTH-1:0]                                 s_data_i,
    output logic                                                  s_ready_o,
    output logic                                                  buff_wea_o,
    output logic [$clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH)-1:0]      buff_addra_o,
    output logic [DATA_WIDTH-1:0]                                 buff_dia_o,
    output logic [10:0]                                           burst_size_o,
    input  logic                                                  weight_ready_i,
    output logic                                                  setup_weight_ready_o,
    input  logic                                                  burst_last_i,
    output logic                                                  busy_o,
    output logic                                                  done_o,
    output logic                                                  err_o
);

    localparam int RW  = $clog2(SRAM_DEPTH);
    localparam int BW  = $clog2(BAND_WIDTH);
    localparam int RCW = RW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_W, RUN, DONE} state_t;

    state_t                  r_state;
    logic [BW-1:0]           r_bank_cnt;
    logic [RCW-1:0]          r_row_cnt;
    logic [10:0]             r_burst_size;
    logic                    r_wea;
    logic [RW+BW-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]   r_dia;
    logic                    r_err;

    logic w_hs;
    logic w_cfg_ok;
    logic w_bank_last;
    logic w_row_last;

    assign s_ready_o            = (r_state == LOAD);
    assign busy_o               = (r_state != IDLE);
    assign done_o               = (r_state == DONE);
    assign setup_weight_ready_o = (r_state == RUN) & weight_ready_i;
    assign buff_wea_o           = r_wea;
    assign buff_addra_o         = r_addr;
    assign buff_dia_o           = r_dia;
    assign burst_size_o         = r_burst_size;
    assign err_o                = r_err;

    assign w_hs        = s_valid_i & s_ready_o;
    assign w_cfg_ok    = (cfg_burst_size_i != 11'd0) && (32'(cfg_burst_size_i) <= 32'(SRAM_DEPTH));
    assign w_bank_last = (r_bank_cnt == BW'(BAND_WIDTH - 1));
    // Row counter is one bit wider than the address row field so a full-depth job still compares cleanly.
    assign w_row_last  = (32'(r_row_cnt) == (32'(r_burst_size) - 32'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bank_cnt   <= '0;
            r_row_cnt    <= '0;
            r_burst_size <= '0;
            r_wea        <= 1'b0;
            r_addr       <= '0;
            r_dia        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_wea <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_start_i) begin
                        if (w_cfg_ok) begin
                            r_burst_size <= cfg_burst_size_i;
                            r_bank_cnt   <= '0;
                            r_row_cnt    <= '0;
                            r_state      <= LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_wea  <= 1'b1;
                        r_addr <= {r_bank_cnt, r_row_cnt[RW-1:0]};
                        r_dia  <= s_data_i;
                        if (w_bank_last) begin
                            r_bank_cnt <= '0;
                            r_row_cnt  <= r_row_cnt + RCW'(1);
                            if (w_row_last) begin
                                r_state <= WAIT_W;
                            end
                        end else begin
                            r_bank_cnt <= r_bank_cnt + BW'(1);
                        end
                    end
                end
                WAIT_W: begin
                    if (weight_ready_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (burst_last_i) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
